// File: rtl/gray_palette_colorizer.sv
// Gray-to-RGB pseudo-colour stage with a double-buffered 16-entry palette.
// Optional PALETTE_INTERP_EN blends adjacent entries by the 4-bit fraction (adds one stage).
module gray_palette_colorizer #(
    parameter logic [7:0] DEF_STEP = 8'd17
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        iValid,
    input  logic [7:0]  iGray,
    input  logic        i_frame_start,
    input  logic        i_pal_we,
    input  logic [3:0]  i_pal_addr,
    input  logic [23:0] i_pal_data,
    input  logic        i_pal_commit,
    output logic [7:0]  oRed,
    output logic [7:0]  oGreen,
    output logic [7:0]  oBlue,
    output logic        oValid,
    output logic        o_commit_pending,
    output logic        o_active_bank
);
    typedef enum logic [0:0] {StIdle, StPending} state_t;

    state_t      r_state;
    logic        r_active;
    logic [23:0] r_bank0 [16];
    logic [23:0] r_bank1 [16];

    logic        r_s1_valid;
    logic        r_s1_bank;
    logic [3:0]  r_s1_idx;
    logic [23:0] r_rgb;
    logic        r_valid;

    logic        w_flip;
    logic        w_eff_bank;
    logic [23:0] w_lo;

    // A flip happens on frame start if a swap is pending or requested this very cycle.
    assign w_flip     = i_frame_start && ((r_state == StPending) || i_pal_commit);
    assign w_eff_bank = r_active ^ w_flip;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_pal_commit && i_frame_start) begin
                        r_active <= ~r_active;
                    end else if (i_pal_commit) begin
                        r_state <= StPending;
                    end
                end
                StPending: begin
                    if (i_frame_start) begin
                        r_active <= ~r_active;
                        r_state  <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Writes always hit the bank inactive before any same-cycle flip.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 16; k++) begin
                r_bank0[k] <= {3{8'(k) * DEF_STEP}};
                r_bank1[k] <= {3{8'(k) * DEF_STEP}};
            end
        end else if (i_pal_we) begin
            if (r_active) begin
                r_bank0[i_pal_addr] <= i_pal_data;
            end else begin
                r_bank1[i_pal_addr] <= i_pal_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_bank  <= 1'b0;
            r_s1_idx   <= 4'd0;
        end else begin
            r_s1_valid <= iValid;
            r_s1_bank  <= w_eff_bank;
            r_s1_idx   <= iGray[7:4];
        end
    end

    assign w_lo = r_s1_bank ? r_bank1[r_s1_idx] : r_bank0[r_s1_idx];

`ifdef PALETTE_INTERP_EN
    logic [3:0]  r_s1_frac;
    logic [3:0]  r_s2_frac;
    logic        r_s2_valid;
    logic [23:0] r_s2_lo;
    logic [23:0] r_s2_hi;
    logic [3:0]  w_idx_hi;
    logic [23:0] w_hi;

    function automatic logic [7:0] mix(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] f);
        logic [11:0] w_a;
        logic [11:0] w_b;
        logic [11:0] w_sum;
        w_a   = {4'd0, a} * (12'd16 - {8'd0, f});
        w_b   = {4'd0, b} * {8'd0, f};
        w_sum = w_a + w_b;
        return w_sum[11:4];
    endfunction

    assign w_idx_hi = (r_s1_idx == 4'hF) ? 4'hF : r_s1_idx + 4'd1;
    assign w_hi     = r_s1_bank ? r_bank1[w_idx_hi] : r_bank0[w_idx_hi];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_frac <= 4'd0;
        end else begin
            r_s1_frac <= iGray[3:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_frac  <= 4'd0;
            r_s2_lo    <= 24'd0;
            r_s2_hi    <= 24'd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_frac <= r_s1_frac;
                r_s2_lo   <= w_lo;
                r_s2_hi   <= w_hi;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_rgb   <= 24'd0;
        end else begin
            r_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_rgb <= {mix(r_s2_lo[23:16], r_s2_hi[23:16], r_s2_frac),
                          mix(r_s2_lo[15:8],  r_s2_hi[15:8],  r_s2_frac),
                          mix(r_s2_lo[7:0],   r_s2_hi[7:0],   r_s2_frac)};
            end
        end
    end
`else
    logic w_unused_frac;
    assign w_unused_frac = ^iGray[3:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_rgb   <= 24'd0;
        end else begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rgb <= w_lo;
            end
        end
    end
`endif

    assign oRed             = r_rgb[23:16];
    assign oGreen           = r_rgb[15:8];
    assign oBlue            = r_rgb[7:0];
    assign oValid           = r_valid;
    assign o_commit_pending = (r_state == StPending);
    assign o_active_bank    = r_active;
endmodule

// File: tb/tb_gray_palette_colorizer.sv
// Bench for gray_palette_colorizer: directed vector table, hand sequences and a random
// run checked every cycle against a palette/bank reference model.
module tb_gray_palette_colorizer;
`ifdef PALETTE_INTERP_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        iValid = 1'b0;
    logic [7:0]  iGray = 8'd0;
    logic        i_frame_start = 1'b0;
    logic        i_pal_we = 1'b0;
    logic [3:0]  i_pal_addr = 4'd0;
    logic [23:0] i_pal_data = 24'd0;
    logic        i_pal_commit = 1'b0;
    logic [7:0]  oRed, oGreen, oBlue;
    logic        oValid, o_commit_pending, o_active_bank;

    int n_tests = 0;
    int n_fail  = 0;

    gray_palette_colorizer dut (
        .i_clk(i_clk), .i_rst(i_rst), .iValid(iValid), .iGray(iGray),
        .i_frame_start(i_frame_start), .i_pal_we(i_pal_we), .i_pal_addr(i_pal_addr),
        .i_pal_data(i_pal_data), .i_pal_commit(i_pal_commit), .oRed(oRed), .oGreen(oGreen),
        .oBlue(oBlue), .oValid(oValid), .o_commit_pending(o_commit_pending),
        .o_active_bank(o_active_bank)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: two palettes, which one is live, pending flag, and a delay line.
    logic [23:0] m_bank [2][16];
    int          m_active = 0;
    int          m_pending = 0;
    logic        m_pv [D];
    logic [23:0] m_pc [D];
    logic        m_ev = 1'b0;
    logic [23:0] m_rgb = 24'd0;

    function automatic logic [23:0] ref_pix(int b, logic [7:0] g);
        int idx = int'(g) / 16;
        logic [23:0] r;
`ifdef PALETTE_INTERP_EN
        int f = int'(g) % 16;
        int nxt = (idx == 15) ? 15 : idx + 1;
        for (int c = 0; c < 3; c++) begin
            int lo = int'(m_bank[b][idx] >> (8 * c)) % 256;
            int hi = int'(m_bank[b][nxt] >> (8 * c)) % 256;
            r[8*c +: 8] = 8'(((lo * (16 - f) + hi * f) % 4096) / 16);
        end
`else
        r = m_bank[b][idx];
`endif
        return r;
    endfunction

    task automatic model_step(input logic v, input logic [7:0] g, input logic fs,
                              input logic we, input logic [3:0] addr, input logic [23:0] data,
                              input logic cm, input logic rst);
        logic flip;
        int   eff;
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < 16; k++) m_bank[b][k] = {3{8'(k * 17)}};
            m_active = 0;
            m_pending = 0;
            for (int k = 0; k < D; k++) m_pv[k] = 1'b0;
            m_ev = 1'b0;
            m_rgb = 24'd0;
        end else begin
            m_ev = m_pv[D-1];
            if (m_ev) m_rgb = m_pc[D-1];
            flip = fs && (m_pending != 0 || cm);
            eff = flip ? 1 - m_active : m_active;
            if (we) m_bank[1 - m_active][addr] = data;
            if (flip) begin
                m_active = 1 - m_active;
                m_pending = 0;
            end else if (cm) begin
                m_pending = 1;
            end
            for (int k = D - 1; k > 0; k--) begin
                m_pv[k] = m_pv[k-1];
                m_pc[k] = m_pc[k-1];
            end
            m_pv[0] = v;
            m_pc[0] = ref_pix(eff, g);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] g, input logic fs, input logic we,
                         input logic [3:0] addr, input logic [23:0] data, input logic cm,
                         input logic rst);
        iValid = v; iGray = g; i_frame_start = fs; i_pal_we = we;
        i_pal_addr = addr; i_pal_data = data; i_pal_commit = cm; i_rst = rst;
        @(posedge i_clk);
        model_step(v, g, fs, we, addr, data, cm, rst);
        #1;
        chk("model_valid", {31'd0, oValid}, {31'd0, m_ev});
        chk("model_rgb", {8'd0, oRed, oGreen, oBlue}, {8'd0, m_rgb});
        chk("model_pending", {31'd0, o_commit_pending}, 32'(m_pending));
        chk("model_bank", {31'd0, o_active_bank}, 32'(m_active));
    endtask

    typedef struct {
        logic v; logic [7:0] g; logic fs; logic we; logic [3:0] addr; logic [23:0] data;
        logic cm; logic rst;
        logic ev; logic [23:0] ergb; logic epend; logic ebank;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        //           v     g      fs    we    addr  data        cm    rst   ev    rgb         pend  bank
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h8C, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h888888, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 4'd8, 24'hFF0000, 1'b0, 1'b0, 1'b0, 24'h888888, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h80, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h888888, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 8'h80, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h888888, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h888888, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h80, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'hFF0000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'hFF0000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'hFF0000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 4'd8, 24'h00FF00, 1'b0, 1'b0, 1'b0, 24'hFF0000, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'hFF0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h00FF00, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h00FF00, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 4'd3, 24'h0A0B0C, 1'b0, 1'b0, 1'b0, 24'h00FF00, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h30, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h00FF00, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h0A0B0C, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'hF0, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h0A0B0C, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'hE0, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h30, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b1, 24'h333333, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h888888, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h888888, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h888888, 1'b0, 1'b0});

        repeat (2) @(posedge i_clk);
        #1;
        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].g, tbl[i].fs, tbl[i].we, tbl[i].addr, tbl[i].data,
                  tbl[i].cm, tbl[i].rst);
`ifndef PALETTE_INTERP_EN
            chk($sformatf("tbl%0d_valid", i), {31'd0, oValid}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_rgb", i), {8'd0, oRed, oGreen, oBlue}, {8'd0, tbl[i].ergb});
            chk($sformatf("tbl%0d_pending", i), {31'd0, o_commit_pending},
                {31'd0, tbl[i].epend});
            chk($sformatf("tbl%0d_bank", i), {31'd0, o_active_bank}, {31'd0, tbl[i].ebank});
`endif
        end

`ifdef PALETTE_INTERP_EN
        // Blend and clamp on a freshly programmed bank 1.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 4'd8, 24'h000000, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 4'd9, 24'hF0F0F0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 4'd15, 24'h123456, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 24'h0, 1'b1, 1'b0);
        cycle(1'b1, 8'h84, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0, 1'b0);
        chk("interp_blend", {7'd0, oValid, oRed, oGreen, oBlue}, {7'd0, 1'b1, 24'h3C3C3C});
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0, 1'b0);
        chk("interp_clamp", {7'd0, oValid, oRed, oGreen, oBlue}, {7'd0, 1'b1, 24'h123456});
`endif

        // Back-to-back sweep over every gray level on the default palette.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0, 1'b1);
        cnt = 0;
        for (int n = 0; n < 256 + D + 1; n++) begin
            cycle(n < 256, 8'(n), 1'b0, 1'b0, 4'd0, 24'h0, 1'b0, 1'b0);
            if (oValid) cnt++;
`ifndef PALETTE_INTERP_EN
            if (n >= D && n < 256 + D)
                chk("sweep_rgb", {8'd0, oRed, oGreen, oBlue},
                    {8'd0, {3{8'(((n - D) / 16) * 17)}}});
`endif
        end
        chk("sweep_count", 32'(cnt), 32'd256);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0, 4'($urandom), 24'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
